// File: rtl/rf_write_queue_2w.sv
// Write-side front end for the 2-write-port register RAMs.
// Takes up to two writeback requests per cycle and buffers them in a circular queue.
// Drains the queue in order onto two RAM write ports, oldest entry on port 1.
// Forwards queued data to two read ports so that readers always see the newest value.
//
// Handshake: a lane request is accepted at a rising edge when its in_valid is high
// and in_ready is high. in_ready depends only on the registered occupancy. A request
// presented while in_ready is low is ignored, and the source holds it until
// in_ready is seen.

`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module rf_write_queue_2w #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = `DATA_LEN,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid1,
  input  logic [ADDR_W-1:0]         in_addr1,
  input  logic [DATA_W-1:0]         in_data1,
  input  logic                      in_valid2,
  input  logic [ADDR_W-1:0]         in_addr2,
  input  logic [DATA_W-1:0]         in_data2,
  output logic                      in_ready,
  input  logic                      drain_en,
  output logic [ADDR_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata1,
  output logic                      we1,
  output logic [ADDR_W-1:0]         waddr2,
  output logic [DATA_W-1:0]         wdata2,
  output logic                      we2,
  input  logic [ADDR_W-1:0]         raddr1,
  input  logic [DATA_W-1:0]         ram_rdata1,
  output logic [DATA_W-1:0]         rdata1,
  input  logic [ADDR_W-1:0]         raddr2,
  input  logic [DATA_W-1:0]         ram_rdata2,
  output logic [DATA_W-1:0]         rdata2,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head1;
  logic [PTR_W-1:0] tail2;

  logic       acc1;
  logic       acc2;
  logic [1:0] n_acc;
  logic [1:0] n_drn;

  // Enqueue side: room for a full pair is needed before either lane is taken.
  always_comb begin
    in_ready = (count <= CNT_W'(QDEPTH - 2));
    acc1     = in_ready & in_valid1;
    acc2     = in_ready & in_valid2;
    n_acc    = {1'b0, acc1} + {1'b0, acc2};
    // Lane 2 lands right after lane 1, or at tail itself when lane 1 is idle.
    tail2    = tail + PTR_W'(acc1);
  end

  // Drain side: head on port 1 and head+1 on port 2; idle ports drive zeros.
  always_comb begin
    head1  = head + PTR_W'(1);
    we1    = drain_en & (count >= CNT_W'(1));
    we2    = drain_en & (count >= CNT_W'(2));
    n_drn  = {1'b0, we1} + {1'b0, we2};
    waddr1 = '0;
    wdata1 = '0;
    waddr2 = '0;
    wdata2 = '0;
    if (we1) begin
      waddr1 = q_addr[head];
      wdata1 = q_data[head];
    end
    if (we2) begin
      waddr2 = q_addr[head1];
      wdata2 = q_data[head1];
    end
  end

  // Read forwarding: walk entries oldest to youngest so that the youngest match wins.
  // Entries being drained this cycle still count, since the RAM only updates at the edge.
  always_comb begin : fwd
    logic [PTR_W-1:0] idx;
    idx    = '0;
    rdata1 = ram_rdata1;
    rdata2 = ram_rdata2;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (q_addr[idx] == raddr1) rdata1 = q_data[idx];
        if (q_addr[idx] == raddr2) rdata2 = q_data[idx];
      end
    end
  end

  // Pointer and occupancy registers; a reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_drn);
      tail  <= tail + PTR_W'(n_acc);
      count <= count + CNT_W'(n_acc) - CNT_W'(n_drn);
    end
  end

  // Entry storage; contents need no reset because count gates every use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (acc1) begin
        q_addr[tail] <= in_addr1;
        q_data[tail] <= in_data1;
      end
      if (acc2) begin
        q_addr[tail2] <= in_addr2;
        q_data[tail2] <= in_data2;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_queue_2w.sv
// Bench for rf_write_queue_2w: directed vectors, expected RAM writes in a queue,
// and a monitor that pops and compares whenever a write port is enabled.

module tb_rf_write_queue_2w;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = $clog2(QDEPTH) + 1;
  localparam int EW     = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid1 = 1'b0;
  logic [ADDR_W-1:0] in_addr1  = '0;
  logic [DATA_W-1:0] in_data1  = '0;
  logic              in_valid2 = 1'b0;
  logic [ADDR_W-1:0] in_addr2  = '0;
  logic [DATA_W-1:0] in_data2  = '0;
  logic              in_ready;
  logic              drain_en  = 1'b0;
  logic [ADDR_W-1:0] waddr1, waddr2;
  logic [DATA_W-1:0] wdata1, wdata2;
  logic              we1, we2;
  logic [ADDR_W-1:0] raddr1 = '0;
  logic [DATA_W-1:0] ram_rdata1 = '0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2 = '0;
  logic [DATA_W-1:0] ram_rdata2 = '0;
  logic [DATA_W-1:0] rdata2;
  logic [CNT_W-1:0]  count;

  rf_write_queue_2w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid1(in_valid1), .in_addr1(in_addr1), .in_data1(in_data1),
    .in_valid2(in_valid2), .in_addr2(in_addr2), .in_data2(in_data2),
    .in_ready(in_ready), .drain_en(drain_en),
    .waddr1(waddr1), .wdata1(wdata1), .we1(we1),
    .waddr2(waddr2), .wdata2(wdata2), .we2(we2),
    .raddr1(raddr1), .ram_rdata1(ram_rdata1), .rdata1(rdata1),
    .raddr2(raddr2), .ram_rdata2(ram_rdata2), .rdata2(rdata2),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input string name, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected write addr 0x%0h data 0x%0h at %0t", name, a, d, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, {11'd0, a, d}, {11'd0, e});
    end
  endtask

  // Monitor: sample write ports on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (we1) check_write("port1_write", waddr1, wdata1);
      else if (waddr1 != '0 || wdata1 != '0) check("port1_idle_zero", {11'd0, waddr1, wdata1}, 32'd0);
      if (we2) check_write("port2_write", waddr2, wdata2);
      else if (waddr2 != '0 || wdata2 != '0) check("port2_idle_zero", {11'd0, waddr2, wdata2}, 32'd0);
      if (we2 && !we1) check("we2_without_we1", 32'd1, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                       input logic v2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
    in_valid1 = v1; in_addr1 = a1; in_data1 = d1;
    in_valid2 = v2; in_addr2 = a2; in_data2 = d2;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Bound on total runtime so a stuck run still reports.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset with three entries queued: everything is discarded.
    drive(1'b1, 5'd12, 16'h0C0C, 1'b1, 5'd13, 16'h0D0D);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd14, 16'h0E0E);
    step();
    idle();
    check("fill_count3", 32'(count), 32'd3);
    check("fill_not_ready", 32'(in_ready), 32'd0);
    raddr1 = 5'd12; ram_rdata1 = 16'h1234;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_we", {30'd0, we1, we2}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_rdata1", 32'(rdata1), 32'h1234);

    // Pair drained on the following cycle; same-cycle requests are not forwarded.
    drain_en = 1'b1;
    raddr2 = 5'd3; ram_rdata2 = 16'h5A5A;
    drive(1'b1, 5'd3, 16'hAAAA, 1'b1, 5'd7, 16'hBBBB);
    #1;
    check("no_fwd_same_cycle", 32'(rdata2), 32'h5A5A);
    expect_wr(5'd3, 16'hAAAA);
    expect_wr(5'd7, 16'hBBBB);
    step();
    idle();
    check("pair_we", {30'd0, we1, we2}, 32'd3);
    check("pair_waddr1", 32'(waddr1), 32'd3);
    check("pair_wdata2", 32'(wdata2), 32'hBBBB);
    step();
    check("pair_count0", 32'(count), 32'd0);

    // Fill to capacity with draining stalled; a third pair is dropped.
    drain_en = 1'b0;
    drive(1'b1, 5'd1, 16'h0011, 1'b1, 5'd2, 16'h0022);
    expect_wr(5'd1, 16'h0011);
    expect_wr(5'd2, 16'h0022);
    step();
    check("full_count2", 32'(count), 32'd2);
    check("full_ready_at2", 32'(in_ready), 32'd1);
    drive(1'b1, 5'd3, 16'h0033, 1'b1, 5'd4, 16'h0044);
    expect_wr(5'd3, 16'h0033);
    expect_wr(5'd4, 16'h0044);
    step();
    check("full_count4", 32'(count), 32'd4);
    check("full_not_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 5'd5, 16'h0055, 1'b1, 5'd6, 16'h0066);
    step();
    idle();
    check("drop_count4", 32'(count), 32'd4);
    check("stall_no_we", {30'd0, we1, we2}, 32'd0);
    drain_en = 1'b1;
    step();
    check("drain_count2", 32'(count), 32'd2);
    step();
    check("drain_count0", 32'(count), 32'd0);

    // Same address on both lanes: port 2 carries the younger value, forwarding shows it.
    drain_en = 1'b0;
    drive(1'b1, 5'd5, 16'h0001, 1'b1, 5'd5, 16'h0002);
    expect_wr(5'd5, 16'h0001);
    expect_wr(5'd5, 16'h0002);
    step();
    idle();
    raddr1 = 5'd5; ram_rdata1 = 16'h7777;
    #1;
    check("same_addr_fwd", 32'(rdata1), 32'h0002);
    drain_en = 1'b1;
    #1;
    check("same_addr_fwd_draining", 32'(rdata1), 32'h0002);
    check("same_addr_wdata1", 32'(wdata1), 32'h0001);
    step();
    check("same_addr_count0", 32'(count), 32'd0);
    check("same_addr_rdata_ram", 32'(rdata1), 32'h7777);

    // Lone lane-2 requests across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, '0, 1'b1, ADDR_W'(i), DATA_W'(i));
      expect_wr(ADDR_W'(i), DATA_W'(i));
      step();
      if (count > CNT_W'(1)) check("wrap_count_le1", 32'(count), 32'd1);
      else n_cmp++;
    end
    idle();
    step();
    check("wrap_count0", 32'(count), 32'd0);

    // Forwarding against RAM data.
    drain_en = 1'b0;
    drive(1'b1, 5'd9, 16'h0055, 1'b0, '0, '0);
    step();
    idle();
    ram_rdata1 = 16'h0011; raddr1 = 5'd9;
    ram_rdata2 = 16'h0022; raddr2 = 5'd9;
    #1;
    check("fwd_rdata1_hit", 32'(rdata1), 32'h0055);
    check("fwd_rdata2_hit", 32'(rdata2), 32'h0055);
    raddr1 = 5'd8;
    #1;
    check("fwd_rdata1_miss", 32'(rdata1), 32'h0011);
    expect_wr(5'd9, 16'h0055);
    drain_en = 1'b1;
    step();
    check("fwd_drained_count", 32'(count), 32'd0);

    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
